lcd_text_buffer: RTL
====================

Name: lcd_text_buffer

Overview:
- 2-line x 16-column character frame buffer. It sits directly upstream of the text-LCD controller, replacing that controller's hard-coded strings.
- A producer (keypad decoder, UART receiver) writes ASCII characters at an auto-advancing cursor and issues clear, home, backspace and newline commands.
- The LCD controller reads characters by address while it streams line 1 and line 2, and uses DIRTY to decide when to redraw.

Parameters:
- FILL_CHAR, 8'h20: character written by reset, clear and backspace.
- SUBST_CHAR, 8'h3F: replaces any non-printable written character (outside 8'h20..8'h7E, except 8'h0A).
- CLEAR_CYCLES, 32: number of cells wiped by a clear. Fixed at 2x16; not to be changed.

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  asynchronous, active-low reset.
- WR_EN  in  1  write WR_CHAR at the cursor (one-cycle pulse per character).
- WR_CHAR  in  8  ASCII code.
- CMD_CLEAR  in  1  wipe the buffer and home the cursor.
- CMD_HOME  in  1  cursor to 0.
- CMD_BS  in  1  backspace.
- RD_ADDR  in  5  read address: [4] = line (0 = line1, 1 = line2), [3:0] = column.
- RD_DATA  out  8  registered read data.
- CURSOR  out  5  current cursor address, same encoding as RD_ADDR.
- BUSY  out  1  clear in progress; all commands and writes are ignored while high.
- DIRTY  out  1  buffer changed since the last acknowledge.
- DIRTY_ACK  in  1  consumer has redrawn; clears DIRTY.

Behaviour:
- Reset (asynchronous, RESETN low):
  - All 32 cells = FILL_CHAR.
  - CURSOR = 0, RD_DATA = 8'h00, BUSY = 0, DIRTY = 1 (forces the first draw).
  - State = IDLE, clear index = 0.
- FSM states:
  - IDLE: accepts commands.
  - CLEAR: BUSY = 1. Writes FILL_CHAR to cell[idx], idx 0..31, one cell per cycle. After idx = 31 it returns to IDLE with CURSOR = 0.
- Command priority in IDLE, one action per cycle: CMD_CLEAR > CMD_HOME > CMD_BS > WR_EN. Lower-priority inputs asserted in the same cycle are dropped, not queued.
- CMD_CLEAR: enter CLEAR next cycle. BUSY is high for exactly 32 cycles. DIRTY is set.
- CMD_HOME: CURSOR <= 0. DIRTY unchanged.
- CMD_BS:
  - If CURSOR = 0: no change, DIRTY not set.
  - Otherwise: CURSOR <= CURSOR-1, then cell[CURSOR-1] <= FILL_CHAR, DIRTY set.
- WR_EN, printable character (8'h20..8'h7E): cell[CURSOR] <= WR_CHAR, then CURSOR <= CURSOR+1 modulo 32 (31 wraps to 0, line2 end to line1 start).
- WR_EN, WR_CHAR = 8'h0A (newline): no cell write. CURSOR <= 16 if CURSOR < 16, else 0. DIRTY not set.
- WR_EN, any other code: treated as a printable write of SUBST_CHAR.
- Any cell write sets DIRTY.
- Read port:
  - RD_DATA <= cell[RD_ADDR] on every clock edge, 1-cycle latency, always active (including during CLEAR).
  - A same-cycle write to the same address returns the old value; the new value appears the following cycle.
- DIRTY_ACK:
  - Clears DIRTY.
  - If a modification happens in the same cycle, set wins and DIRTY stays 1.
- Reset asserted mid-CLEAR: immediate return to the reset state. The result is the same as a completed clear, plus DIRTY = 1.
- All outputs are registered; there is no combinational path from any input to any output.

Decomposition:
- Shared package lcd_pkg:
  - ASCII constants: FILL, SUBST, NEWLINE, PRINT_MIN = 8'h20, PRINT_MAX = 8'h7E.
  - Address constants: LINE1_BASE = 5'd0, LINE2_BASE = 5'd16.
  - LCD controller command codes shared with the downstream controller: 8'h80 line1, 8'hC0 line2, 8'h01 clear.
  - State encoding: IDLE = 1'b0, CLEAR = 1'b1.
- One natural sub-module: lcd_cursor_ctrl, which computes the next cursor value and the write enable/address/data from the command inputs.
- The cell array and the FSM stay in the top module.

Test Plan:
- Reset release → every read of addresses 0..31 gives 8'h20; CURSOR = 0; DIRTY = 1; BUSY = 0.
- Write "20174" (8'h32,8'h30,8'h31,8'h37,8'h34) → CURSOR = 5; reads of addresses 0..4 return those bytes 1 cycle after RD_ADDR is applied; DIRTY = 1. Pulse DIRTY_ACK → DIRTY = 0.
- Write 33 x 8'h41 from cursor 0 → CURSOR = 1 (wrapped past 31); all cells = 8'h41.
- Write 8'h0A at CURSOR = 3 → CURSOR = 16. Write 8'h0A again → CURSOR = 0. Write 8'h07 → cell = 8'h3F.
- At CURSOR = 2, pulse CMD_BS → CURSOR = 1, cell[1] = 8'h20. Repeat twice more → CURSOR = 0; the third BS leaves DIRTY unchanged.
- Assert CMD_CLEAR and WR_EN together → only the clear runs; BUSY is high for exactly 32 cycles. A WR_EN pulsed during BUSY has no effect. Afterwards all cells = 8'h20 and CURSOR = 0. Assert RESETN low at clear cycle 10 → reset values restored immediately.

Source files
------------

// File: rtl/lcd_text_buffer_pkg.sv
// Shared constants for the 2x16 text frame buffer and the downstream LCD controller.
// Holds character codes, cell addressing, controller command bytes and the FSM encoding.
package lcd_pkg;

    localparam logic [7:0] FILL      = 8'h20;
    localparam logic [7:0] SUBST     = 8'h3F;
    localparam logic [7:0] NEWLINE   = 8'h0A;
    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    localparam int LINE_COLS    = 16;
    localparam int CELL_COUNT   = 2 * LINE_COLS;
    localparam int CLEAR_CYCLES = CELL_COUNT;

    localparam logic [4:0] LINE1_BASE = 5'd0;
    localparam logic [4:0] LINE2_BASE = 5'd16;

    // Command bytes the LCD controller issues; kept here so both sides agree.
    localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    typedef struct packed {
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
    } cell_wr_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PRINT_MIN) && (c <= PRINT_MAX);
    endfunction

endpackage

// File: rtl/lcd_text_buffer_if.sv
// Producer/consumer side of the text buffer: character writes, cursor commands,
// the LCD controller's read port and the redraw handshake.
interface lcd_text_buffer_if;

    logic       WR_EN;
    logic [7:0] WR_CHAR;
    logic       CMD_CLEAR;
    logic       CMD_HOME;
    logic       CMD_BS;
    logic [4:0] RD_ADDR;
    logic [7:0] RD_DATA;
    logic [4:0] CURSOR;
    logic       BUSY;
    logic       DIRTY;
    logic       DIRTY_ACK;

    modport master (
        output WR_EN, WR_CHAR, CMD_CLEAR, CMD_HOME, CMD_BS, RD_ADDR, DIRTY_ACK,
        input  RD_DATA, CURSOR, BUSY, DIRTY
    );

    modport slave (
        input  WR_EN, WR_CHAR, CMD_CLEAR, CMD_HOME, CMD_BS, RD_ADDR, DIRTY_ACK,
        output RD_DATA, CURSOR, BUSY, DIRTY
    );

endinterface

// File: rtl/lcd_text_buffer_cursor_ctrl.sv
// Decodes one producer action per cycle into the next cursor value and a cell write.
// Priority is clear > home > backspace > write; lower-priority inputs are dropped.
module lcd_cursor_ctrl
    import lcd_pkg::*;
#(
    parameter logic [7:0] FILL_CHAR  = FILL,
    parameter logic [7:0] SUBST_CHAR = SUBST
) (
    input  logic       idle,
    input  logic [4:0] cursor,
    input  logic       wr_en,
    input  logic [7:0] wr_char,
    input  logic       cmd_clear,
    input  logic       cmd_home,
    input  logic       cmd_bs,
    output logic [4:0] cursor_nxt,
    output cell_wr_t   cell_wr,
    output logic       clear_start,
    output logic       modified
);

    always_comb begin
        cursor_nxt  = cursor;
        cell_wr     = '0;
        clear_start = 1'b0;
        modified    = 1'b0;
        if (idle) begin
            if (cmd_clear) begin
                clear_start = 1'b1;
                modified    = 1'b1;
            end else if (cmd_home) begin
                cursor_nxt = LINE1_BASE;
            end else if (cmd_bs) begin
                if (cursor != LINE1_BASE) begin
                    cursor_nxt   = cursor - 5'd1;
                    cell_wr.we   = 1'b1;
                    cell_wr.addr = cursor - 5'd1;
                    cell_wr.data = FILL_CHAR;
                    modified     = 1'b1;
                end
            end else if (wr_en) begin
                // Newline only moves the cursor to the start of the other line.
                if (wr_char == NEWLINE) begin
                    cursor_nxt = cursor[4] ? LINE1_BASE : LINE2_BASE;
                end else begin
                    cell_wr.we   = 1'b1;
                    cell_wr.addr = cursor;
                    cell_wr.data = is_printable(wr_char) ? wr_char : SUBST_CHAR;
                    cursor_nxt   = cursor + 5'd1;
                    modified     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_text_buffer.sv
// 2-line x 16-column character frame buffer feeding the text-LCD controller.
// Holds the cell array, the clear sequencer and the registered read port.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | accepting one command or character write per cycle
//   ST_CLEAR | BUSY; writing FILL_CHAR to one cell per cycle, idx 0..31
module lcd_text_buffer
    import lcd_pkg::*;
#(
    parameter logic [7:0] FILL_CHAR  = FILL,
    parameter logic [7:0] SUBST_CHAR = SUBST
) (
    input logic              CLK,
    input logic              RESETN,
    lcd_text_buffer_if.slave bus
);

    localparam logic [4:0] LAST_IDX = 5'(CLEAR_CYCLES - 1);

    logic [7:0] cell_mem [CELL_COUNT];
    logic [0:0] state;
    logic [4:0] clr_idx;
    logic [4:0] cursor;
    logic [7:0] rd_data;
    logic       dirty;

    logic       idle;
    logic [4:0] cursor_nxt;
    cell_wr_t   ctrl_wr;
    cell_wr_t   cell_wr;
    logic       clear_start;
    logic       ctrl_mod;
    logic       dirty_set;

    assign idle = (state == ST_IDLE);

    lcd_cursor_ctrl #(
        .FILL_CHAR  (FILL_CHAR),
        .SUBST_CHAR (SUBST_CHAR)
    ) u_cursor_ctrl (
        .idle        (idle),
        .cursor      (cursor),
        .wr_en       (bus.WR_EN),
        .wr_char     (bus.WR_CHAR),
        .cmd_clear   (bus.CMD_CLEAR),
        .cmd_home    (bus.CMD_HOME),
        .cmd_bs      (bus.CMD_BS),
        .cursor_nxt  (cursor_nxt),
        .cell_wr     (ctrl_wr),
        .clear_start (clear_start),
        .modified    (ctrl_mod)
    );

    // The clear sequencer owns the write port while it runs.
    always_comb begin
        cell_wr = ctrl_wr;
        if (state == ST_CLEAR) begin
            cell_wr.we   = 1'b1;
            cell_wr.addr = clr_idx;
            cell_wr.data = FILL_CHAR;
        end
    end

    assign dirty_set = ctrl_mod || (state == ST_CLEAR);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < CELL_COUNT; i++) begin
                cell_mem[i] <= FILL_CHAR;
            end
        end else if (cell_wr.we) begin
            cell_mem[cell_wr.addr] <= cell_wr.data;
        end
    end

    // Read sees the pre-write contents of a cell written in the same cycle.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= cell_mem[bus.RD_ADDR];
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state   <= ST_IDLE;
            clr_idx <= 5'd0;
            cursor  <= LINE1_BASE;
        end else begin
            case (state)
                ST_IDLE: begin
                    cursor <= cursor_nxt;
                    if (clear_start) begin
                        state   <= ST_CLEAR;
                        clr_idx <= 5'd0;
                    end
                end
                ST_CLEAR: begin
                    clr_idx <= clr_idx + 5'd1;
                    if (clr_idx == LAST_IDX) begin
                        state  <= ST_IDLE;
                        cursor <= LINE1_BASE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A modification in the acknowledge cycle wins so no change is lost.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            dirty <= 1'b1;
        end else if (dirty_set) begin
            dirty <= 1'b1;
        end else if (bus.DIRTY_ACK) begin
            dirty <= 1'b0;
        end
    end

    assign bus.RD_DATA = rd_data;
    assign bus.CURSOR  = cursor;
    assign bus.BUSY    = (state == ST_CLEAR);
    assign bus.DIRTY   = dirty;

endmodule
